sap1_controller_sequencer: RTL
==============================

# sap1_controller_sequencer

SAP-1 controller-sequencer: a six-state ring counter (T1–T6) that steps the machine through fetch and execute. It combines the ring state with the opcode-decoder outputs (`lda`, `add`, `sub`, `out`, `LOW_HALT`) to drive the 12-bit control word to the PC, MAR, RAM, IR, accumulator, ALU, B and output registers. Datapath registers load on the rising edge of `clk`. This block changes state on the falling edge, so the control word is stable a half-cycle before each load.

## Interface
- No parameters.
- `clk`  in  1  system clock; ring state advances on the falling edge
- `clr`  in  1  asynchronous, active-high reset
- `lda`  in  1  decoded LDA (opcode 0000), valid from T4
- `add`  in  1  decoded ADD (0001), valid from T4
- `sub`  in  1  decoded SUB (0010), valid from T4
- `out`  in  1  decoded OUT (1110), valid from T4
- `LOW_HALT`  in  1  active-low decoded HLT (1111), valid from T4
- `con`  out  12  control word {Cp, Ep, LM_n, CE_n, LI_n, EI_n, LA_n, Ea, Su, Eu, LB_n, LO_n}, bit 11 first
- `ring`  out  6  one-hot state, bit0 = T1 … bit5 = T6; 000000 when halted
- `halted`  out  1  high while in HALT

## Operation
- Inactive word = 12'h3E3 (all enables low, all `_n` loads high).
- Fetch, identical for all instructions:
  - T1 = 5E3 (Ep, LM_n)
  - T2 = BE3 (Cp)
  - T3 = 263 (CE_n, LI_n)
- LDA:
  - T4 = 1A3 (EI_n, LM_n)
  - T5 = 2C3 (CE_n, LA_n)
  - T6 = 3E3
- ADD:
  - T4 = 1A3
  - T5 = 2E1 (CE_n, LB_n)
  - T6 = 3C7 (LA_n, Eu)
- SUB: as ADD, except T6 = 3CF (LA_n, Eu, Su).
- OUT:
  - T4 = 3F2 (Ea, LO_n)
  - T5 = 3E3
  - T6 = 3E3
- Undefined opcode (no decode line active, `LOW_HALT` = 1): T4–T6 = 3E3; the opcode executes as a NOP.
- HLT: if `LOW_HALT` = 0 while in T4, the next falling edge enters HALT.
  - In HALT: `ring` = 000000, `halted` = 1, `con` = 3E3.
  - HALT holds regardless of inputs until `clr` is asserted.
- Priority in T4: `LOW_HALT` = 0 overrides any other decode line. If more than one of `lda`/`add`/`sub`/`out` is high, the priority is LDA > ADD > SUB > OUT.
- `con` is a combinational function of the registered state and the decode lines. The decode lines are sampled only in T4–T6.
- Transitions (falling edge): T1→T2→T3→T4→T5→T6→T1, except T4→HALT on halt.

## Timing
- Reset values, held while `clr` = 1:
  - `ring` = 000001
  - `halted` = 0
  - `con` = 3E3 (forced inactive while `clr` is high)
- After `clr` deasserts:
  - `con` = 5E3 immediately.
  - The first falling edge moves to T2.
- `clr` asserted mid-instruction, including T5/T6 or HALT: the state goes to T1 at once, with no pending loads completed.
- The state register is never in an unreachable pattern. Any non-one-hot `ring` value with `halted` = 0 recovers to T1 on the next falling edge.
- Instruction length: 6 clocks (fixed), unless the macro below is defined.
- Halt latency: the HALT state is entered on the falling edge that ends T4, which is the 4th falling edge after the HLT fetch starts in T1.

## Configuration
- Macro: `SAP1_SKIP_NOP_EN`.
- Defined: trailing all-NOP states are skipped by the falling-edge transition.
  - LDA: T5→T1 (5 clocks).
  - OUT: T4→T1 (4 clocks).
  - Undefined opcode: T4→T1 (4 clocks).
  - ADD and SUB: unchanged (6 clocks).
  - HLT: unchanged.
- Not defined: a fixed 6-state cycle for every instruction.
- The `con` values per state are identical in both builds.

## Test plan
- Reset: pulse `clr` mid-T5 of an ADD -> `ring` = 000001 and `con` = 3E3 asynchronously; after release `con` = 5E3, then `con` = BE3 after the next falling edge.
- LDA, from reset with `lda` = 1 from T4 -> `con` sequence 5E3, BE3, 263, 1A3, 2C3, 3E3, then back to 5E3. Under `SAP1_SKIP_NOP_EN`, 2C3 is followed directly by 5E3.
- ADD, then SUB -> ADD gives T4–T6 = 1A3, 2E1, 3C7; SUB gives 1A3, 2E1, 3CF.
- OUT -> T4 = 3F2, T5 = T6 = 3E3. Under the macro, T4 is followed directly by T1 (5E3).
- HLT, `LOW_HALT` = 0 in T4 -> after that falling edge `ring` = 000000, `halted` = 1, `con` = 3E3; stays there for 20 clocks with toggling decode inputs; `clr` -> T1.
- Conflicts: `LOW_HALT` = 0 with `add` = 1 in T4 -> enters HALT. `lda` = `out` = 1 -> LDA words. Undefined opcode -> T4–T6 = 3E3.

Source files
------------

// File: rtl/sap1_controller_sequencer.sv
// sap1_controller_sequencer
//
// SAP-1 controller-sequencer. A six-state one-hot ring (T1..T6) steps the
// machine through fetch (T1-T3) and execute (T4-T6). The ring advances on the
// falling edge of clk so the control word settles half a cycle before the
// datapath registers load on the rising edge.
//
// Ports:
//   clk       in   system clock, state advances on the falling edge
//   clr       in   asynchronous active-high reset (returns to T1)
//   lda       in   decoded LDA, valid from T4
//   add       in   decoded ADD, valid from T4
//   sub       in   decoded SUB, valid from T4
//   out       in   decoded OUT, valid from T4
//   LOW_HALT  in   active-low decoded HLT, valid from T4
//   con       out  control word {Cp,Ep,LM_n,CE_n,LI_n,EI_n,LA_n,Ea,Su,Eu,LB_n,LO_n}
//   ring      out  one-hot state, bit0 = T1 .. bit5 = T6, all zero when halted
//   halted    out  high while in HALT
//
// Build option: define SAP1_SKIP_NOP_EN to skip trailing all-NOP states
// (LDA ends after T5, OUT and undefined opcodes end after T4).

module sap1_controller_sequencer (
    input  logic        clk,
    input  logic        clr,
    input  logic        lda,
    input  logic        add,
    input  logic        sub,
    input  logic        out,
    input  logic        LOW_HALT,
    output logic [11:0] con,
    output logic [5:0]  ring,
    output logic        halted
);

    localparam logic [5:0] T1   = 6'b000001;
    localparam logic [5:0] T2   = 6'b000010;
    localparam logic [5:0] T3   = 6'b000100;
    localparam logic [5:0] T4   = 6'b001000;
    localparam logic [5:0] T5   = 6'b010000;
    localparam logic [5:0] T6   = 6'b100000;
    localparam logic [5:0] HALT = 6'b000000;

    localparam logic [11:0] W_IDLE    = 12'h3E3;
    localparam logic [11:0] W_FETCH1  = 12'h5E3;
    localparam logic [11:0] W_FETCH2  = 12'hBE3;
    localparam logic [11:0] W_FETCH3  = 12'h263;
    localparam logic [11:0] W_ADDR    = 12'h1A3;
    localparam logic [11:0] W_LDA5    = 12'h2C3;
    localparam logic [11:0] W_LOADB   = 12'h2E1;
    localparam logic [11:0] W_ADD6    = 12'h3C7;
    localparam logic [11:0] W_SUB6    = 12'h3CF;
    localparam logic [11:0] W_OUT4    = 12'h3F2;

    logic [5:0] ring_q;
    logic [5:0] ring_d;
    logic       halted_q;
    logic       halted_d;

    // Priority-resolved decode: HLT wins in T4, then LDA > ADD > SUB > OUT.
    logic dec_hlt;
    logic dec_lda;
    logic dec_add;
    logic dec_sub;
    logic dec_out;
    logic dec_mem;

    assign dec_hlt = ~LOW_HALT;
    assign dec_lda = lda;
    assign dec_add = ~lda & add;
    assign dec_sub = ~lda & ~add & sub;
    assign dec_out = ~lda & ~add & ~sub & out;
    assign dec_mem = lda | add | sub;

    always_comb begin
        ring_d   = T1;
        halted_d = halted_q;
        if (halted_q) begin
            ring_d = HALT;
        end else begin
            case (ring_q)
                T1: ring_d = T2;
                T2: ring_d = T3;
                T3: ring_d = T4;
                T4: begin
                    if (dec_hlt) begin
                        ring_d   = HALT;
                        halted_d = 1'b1;
                    end else begin
`ifdef SAP1_SKIP_NOP_EN
                        // OUT and undefined opcodes have nothing left after T4.
                        ring_d = dec_mem ? T5 : T1;
`else
                        ring_d = T5;
`endif
                    end
                end
                T5: begin
`ifdef SAP1_SKIP_NOP_EN
                    // LDA's T6 is empty.
                    ring_d = dec_lda ? T1 : T6;
`else
                    ring_d = T6;
`endif
                end
                T6:      ring_d = T1;
                // Any corrupted (non one-hot) pattern restarts the fetch.
                default: ring_d = T1;
            endcase
        end
    end

    always_ff @(negedge clk or posedge clr) begin
        if (clr) begin
            ring_q   <= T1;
            halted_q <= 1'b0;
        end else begin
            ring_q   <= ring_d;
            halted_q <= halted_d;
        end
    end

    // Control word: combinational from the registered state and decode lines,
    // forced inactive during reset and in HALT.
    always_comb begin
        con = W_IDLE;
        if (!clr && !halted_q) begin
            case (ring_q)
                T1: con = W_FETCH1;
                T2: con = W_FETCH2;
                T3: con = W_FETCH3;
                T4: begin
                    if (!dec_hlt) begin
                        if (dec_mem)      con = W_ADDR;
                        else if (dec_out) con = W_OUT4;
                    end
                end
                T5: begin
                    if (dec_lda)                con = W_LDA5;
                    else if (dec_add | dec_sub) con = W_LOADB;
                end
                T6: begin
                    if (dec_add)      con = W_ADD6;
                    else if (dec_sub) con = W_SUB6;
                end
                default: con = W_IDLE;
            endcase
        end
    end

    assign ring   = ring_q;
    assign halted = halted_q;

endmodule
